mult_seq_32x32: RTL and testbench

- Sequential 32x32 multiply unit for the MIPS datapath: executes MULT/MULTU and writes the 64-bit product into HI/LO.
- Instantiates one 16x16 combinational karatsuba_16 and time-multiplexes it over four cycles to form the four 16-bit partial products.
- Sits between the ID/EX operand latch (upstream) and the HI/LO read path for MFHI/MFLO (downstream).

---
 rtl/mult_seq_32x32.sv | 127 ++++++++++++
 tb/tb_mult_seq_32x32.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mult_seq_32x32.sv
// mult_seq_32x32: sequential 32x32 MULT/MULTU into HI/LO, one 16x16 karatsuba core reused over four cycles.
// Optional MADD/MADDU accumulate into HI/LO is built when MULT_ACC_EN is defined.

// karatsuba_16: combinational 16x16 unsigned multiply from three 8-bit-ish products
module karatsuba_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] z0, z2;
  logic [8:0]  sa, sb;
  logic [17:0] z1;
  // z1 = (aH+aL)(bH+bL) - aH*bH - aL*bL = aH*bL + aL*bH
  always_comb begin
    z0 = {8'b0, a[7:0]} * {8'b0, b[7:0]};
    z2 = {8'b0, a[15:8]} * {8'b0, b[15:8]};
    sa = {1'b0, a[15:8]} + {1'b0, a[7:0]};
    sb = {1'b0, b[15:8]} + {1'b0, b[7:0]};
    z1 = {9'b0, sa} * {9'b0, sb} - {2'b0, z2} - {2'b0, z0};
    p  = {z2, z0} + {6'b0, z1, 8'b0};
  end
endmodule

module mult_seq_32x32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic        acc,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, FIN} state_t;
  state_t      state;
  logic [31:0] a, b, abs_a, abs_b, pp;
  logic [15:0] ka, kb;
  logic [63:0] acc64, sum, res, wr;
  logic        neg;
`ifdef MULT_ACC_EN
  logic        acc_q;
`else
  logic        unused_acc;
  assign unused_acc = acc;
`endif

  karatsuba_16 u_k (.a(ka), .b(kb), .p(pp));

  assign busy = ~ready;

  // operand magnitudes, partial-product select/shift by state, and final sign/accumulate
  always_comb begin
    abs_a = (is_signed & op_a[31]) ? -op_a : op_a;
    abs_b = (is_signed & op_b[31]) ? -op_b : op_b;
    ka    = (state == PP2 || state == PP3) ? a[31:16] : a[15:0];
    kb    = (state == PP1 || state == PP3) ? b[31:16] : b[15:0];
    sum   = acc64 + ((state == PP3) ? {pp, 32'b0} :
                     (state == PP0) ? {32'b0, pp} : {16'b0, pp, 16'b0});
    res   = neg ? ~acc64 + 64'd1 : acc64;
`ifdef MULT_ACC_EN
    wr    = acc_q ? {hi, lo} + res : res;
`else
    wr    = res;
`endif
  end

  // control FSM with registered handshake outputs; HI/LO written only in FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      acc64 <= '0;
      a     <= '0;
      b     <= '0;
      neg   <= 1'b0;
`ifdef MULT_ACC_EN
      acc_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          ready <= ~start;
          if (start) begin
            a     <= abs_a;
            b     <= abs_b;
            neg   <= is_signed & (op_a[31] ^ op_b[31]);
            acc64 <= '0;
`ifdef MULT_ACC_EN
            acc_q <= acc;
`endif
            state <= PP0;
          end
        end
        PP0: begin
          acc64 <= sum;
          state <= PP1;
        end
        PP1: begin
          acc64 <= sum;
          state <= PP2;
        end
        PP2: begin
          acc64 <= sum;
          state <= PP3;
        end
        PP3: begin
          acc64 <= sum;
          state <= FIN;
        end
        FIN: begin
          {hi, lo} <= wr;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_seq_32x32.sv
// tb_mult_seq_32x32: directed vectors plus a cycle-level product model checked every cycle.
module tb_mult_seq_32x32;
  logic        clk = 0, rst_n = 0, start = 0, is_signed = 0, acc = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic        ready, busy, done;
  logic [31:0] hi, lo;
  int          n_cmp = 0, n_err = 0;

`ifdef MULT_ACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  mult_seq_32x32 dut (.clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .acc(acc),
                      .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy), .done(done),
                      .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] product(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xx, yy;
    xx = s ? {{32{x[31]}}, x} : {32'b0, x};
    yy = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xx * yy;
  endfunction

  logic [63:0] m_hl = 0, m_p = 0;
  int          m_cnt = 0;
  logic        m_done = 0, m_acc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hl = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_cnt == 0) begin
        if (start) begin
          m_p = product(op_a, op_b, is_signed); m_acc = acc; m_cnt = 5;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hl = (MACC && m_acc) ? m_hl + m_p : m_p;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("done", {63'b0, done}, {63'b0, m_done});
      chk("ready", {63'b0, ready}, {63'b0, (m_cnt == 0 && !m_done)});
      chk("busy", {63'b0, busy}, {63'b0, !(m_cnt == 0 && !m_done)});
      chk("hilo", {hi, lo}, m_hl);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 20) begin @(negedge clk); k++; end
    chk("wait_ready", {63'b0, ready}, 64'd1);
  endtask

  task automatic wait_done(input string nm, input logic [63:0] exp);
    int k = 0;
    while (!done && k < 12) begin @(negedge clk); k++; end
    chk({nm, "_done"}, {63'b0, done}, 64'd1);
    chk(nm, {hi, lo}, exp);
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic s, input logic ac,
                    input logic [63:0] exp, input string nm);
    wait_ready();
    op_a = x; op_b = y; is_signed = s; acc = ac; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(nm, exp);
  endtask

  initial begin
    int cnt;
    #12;
    chk("rst_ready", {63'b0, ready}, 64'd1);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 64'hFFFFFFFE_00000001, "multu_max");
    op(32'hFFFFFFFD, 32'd7, 0, 0, 64'h00000006_FFFFFFEB, "multu_m3x7");
    op(32'hFFFFFFFD, 32'd7, 1, 0, 64'hFFFFFFFF_FFFFFFEB, "mult_m3x7");
    op(32'h80000000, 32'h80000000, 1, 0, 64'h40000000_00000000, "mult_min_sq");
    op(32'h80000000, 32'hFFFFFFFF, 1, 0, 64'h00000000_80000000, "mult_min_m1");
    op(32'h00000000, 32'hFFFFFFFF, 1, 0, 64'd0, "mult_zero");
    op(32'h12345678, 32'h9ABCDEF0, 0, 0, 64'h0B00EA4E_242D2080, "multu_mix");
    // start held high: accepts every 6 cycles
    wait_ready();
    op_a = 2; op_b = 3; is_signed = 0; acc = 0; start = 1;
    cnt = 0;
    repeat (18) begin @(negedge clk); if (done) cnt++; end
    start = 0;
    chk("cont_dones", cnt, 3);
    chk("cont_val", {hi, lo}, 64'd6);
    // operand change at E1 and start pulse at E2 have no effect
    wait_ready();
    op_a = 3; op_b = 5; start = 1;
    @(negedge clk); start = 0; op_a = 100; op_b = 100;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    wait_done("ignore_e1e2", 64'd15);
    // reset in PP2 aborts
    wait_ready();
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    chk("mid_rst_ready", {63'b0, ready}, 64'd1);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    chk("mid_rst_nodone", {63'b0, done}, 64'd0);
    #2 rst_n = 1;
    @(negedge clk);
    op(32'd12345, 32'd678, 0, 0, 64'h00000000_007FB6F6, "after_rst");
    op(32'd3, 32'd4, 0, 0, 64'd12, "acc_first");
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, MACC ? 64'hFFFFFFFE_0000000D : 64'hFFFFFFFE_00000001, "acc_second");
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
